// File: rtl/uart_pkg.sv
// uart_pkg: constants and FSM state encoding shared by the UART receiver and transmitter.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_pkg;

  // Number of tick_x8 enable pulses in one bit period.
  localparam int OVERSAMPLE_X8 = 8;

  // Receiver frame-tracking states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for a single asynchronous input.
// RESET_VAL sets the value both stages take under reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture so downstream logic never sees a metastable value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8x-oversampled UART receiver with a one-entry output buffer.
// Frame: start + DATA_BITS (LSB first) [+ parity] + stop.
// Optional feature macro: UART_RX_PARITY_EN adds PARITY_ODD and parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_X8
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 tick_x8,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err
`ifdef UART_RX_PARITY_EN
  , output logic               parity_err
`endif
);

  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  // START waits half a bit, everything else a full bit.
  localparam logic [2:0]       MID_TICK  = 3'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0]       LAST_TICK = 3'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_STEP  = BIT_W'(1);

`ifdef UART_RX_PARITY_EN
  // True when data plus received parity bit disagree with the configured sense.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] data,
                                      input logic par_bit);
    return ((^data) ^ par_bit) != PARITY_ODD;
  endfunction
`endif

  logic                 rxd_s;
  uart_state_e          state_q;
  logic [2:0]           tick_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 overrun_err_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q;
  logic                 parity_err_q;
`endif

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i (sys_clk),
    .rst_i (rst),
    .d_i   (rxd),
    .q_o   (rxd_s)
  );

  // Shift register contents after sampling one data bit (line is LSB first).
  always_comb begin
    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
  end

  // Frame FSM, counters, output buffer and error pulses.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tick_cnt_q    <= 3'd0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
      // Consumer handshake; a frame accepted this same cycle overrides below.
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      if (tick_x8) begin
        case (state_q)
          ST_IDLE: begin
            if (!rxd_s) begin
              state_q    <= ST_START;
              tick_cnt_q <= 3'd0;
            end
          end

          ST_START: begin
            if (tick_cnt_q == MID_TICK) begin
              tick_cnt_q <= 3'd0;
              bit_cnt_q  <= '0;
              // A start bit that is gone by mid-bit was noise.
              state_q    <= rxd_s ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt_q <= tick_cnt_q + 3'd1;
            end
          end

          ST_DATA: begin
            if (tick_cnt_q == LAST_TICK) begin
              tick_cnt_q <= 3'd0;
              shift_q    <= shift_d;
              if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                state_q   <= ST_PARITY;
`else
                state_q   <= ST_STOP;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_q + BIT_STEP;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 3'd1;
            end
          end

`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            if (tick_cnt_q == LAST_TICK) begin
              tick_cnt_q <= 3'd0;
              par_bad_q  <= parity_bad(shift_q, rxd_s);
              state_q    <= ST_STOP;
            end else begin
              tick_cnt_q <= tick_cnt_q + 3'd1;
            end
          end
`endif

          ST_STOP: begin
            if (tick_cnt_q == LAST_TICK) begin
              tick_cnt_q <= 3'd0;
              if (rxd_s) begin
                state_q <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= par_bad_q;
`endif
                if (rx_valid_q && !rx_ready) begin
                  // Buffer still owned by the consumer: keep the old byte.
                  overrun_err_q <= 1'b1;
                end else begin
                  rx_data_q  <= shift_q;
                  rx_valid_q <= 1'b1;
                end
              end else begin
                // Low stop bit: drop the byte and wait out the break.
                frame_err_q <= 1'b1;
                state_q     <= ST_BREAK;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 3'd1;
            end
          end

          ST_BREAK: begin
            if (rxd_s) begin
              state_q    <= ST_IDLE;
              tick_cnt_q <= 3'd0;
            end
          end

          default: begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= 3'd0;
            bit_cnt_q  <= '0;
          end
        endcase
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scenario tasks for uart_rx with a received-byte scoreboard.
// tick_x8 pulses every 4 sys_clk, so one bit lasts 32 sys_clk.
module tb_uart_rx;

  localparam int BIT_CLKS = 32;

  logic       sys_clk;
  logic       rst;
  logic       tick_x8;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip;
  int         perr_cnt = 0;
`endif

  int checks   = 0;
  int failures = 0;

  int ferr_cnt     = 0;
  int ovr_cnt      = 0;
  int valid_cycles = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [1:0] tick_div = 2'd0;

  uart_rx #(
    .DATA_BITS  (8),
    .OVERSAMPLE (8)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .tick_x8     (tick_x8),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
`ifdef UART_RX_PARITY_EN
    , .parity_err (parity_err)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Baud enable: one-cycle pulse every fourth clock.
  initial begin
    tick_x8 = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      tick_x8  = (tick_div == 2'd3);
      tick_div = tick_div + 2'd1;
    end
  end

  // Output monitor on the falling edge: handshakes feed the scoreboard, pulses are counted.
  always @(negedge sys_clk) begin
    if (rx_valid) valid_cycles <= valid_cycles + 1;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun_err) ovr_cnt <= ovr_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt <= perr_cnt + 1;
`endif
  end

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    step(BIT_CLKS);
  endtask

  // Idle gap, start, data LSB first, [parity], stop; a low stop can be stretched into a break.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int gap_clks, input int hold_low_bits);
    rxd = 1'b1;
    step(gap_clks);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^data) ^ par_flip);
`endif
    send_bit(stop_bit);
    if (!stop_bit) begin
      rxd = 1'b0;
      step(BIT_CLKS * hold_low_bits);
    end
    rxd = 1'b1;
  endtask

  task automatic wait_got(input int n);
    for (int i = 0; i < 400 && got_q.size() < n; i++) step(1);
  endtask

  task automatic pop_pair(output logic [7:0] e, output logic [7:0] g);
    e = exp_q.pop_front();
    g = 8'hxx;
    if (got_q.size() > 0) g = got_q.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxd = 1'b1;
    rx_ready = 1'b0;
    step(6);
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", overrun_err); end
    rst = 1'b0;
    step(4);
  endtask

  task automatic test_basic();
    int f0, o0, v0;
    logic [7:0] e, g;
    rx_ready = 1'b1;
    f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cycles;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 16, 0);
    wait_got(1);
    step(4);
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL basic_count got=%0d exp=1", got_q.size()); end
    pop_pair(e, g);
    checks++; if (g !== e) begin failures++; $display("FAIL basic_data got=%h exp=%h", g, e); end
    checks++; if (valid_cycles - v0 !== 1) begin failures++; $display("FAIL basic_valid_cycles got=%0d exp=1", valid_cycles - v0); end
    checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL basic_ferr got=%0d exp=0", ferr_cnt - f0); end
    checks++; if (ovr_cnt - o0 !== 0) begin failures++; $display("FAIL basic_ovr got=%0d exp=0", ovr_cnt - o0); end
  endtask

  task automatic test_glitch();
    int f0, v0;
    logic [7:0] e, g;
    f0 = ferr_cnt; v0 = valid_cycles;
    rxd = 1'b0;
    step(8);
    rxd = 1'b1;
    step(100);
    checks++; if (valid_cycles - v0 !== 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", valid_cycles - v0); end
    checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt - f0); end
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 16, 0);
    wait_got(1);
    pop_pair(e, g);
    checks++; if (g !== e) begin failures++; $display("FAIL glitch_next_data got=%h exp=%h", g, e); end
  endtask

  task automatic test_frame_err_break();
    int f0, v0;
    logic [7:0] e, g;
    f0 = ferr_cnt; v0 = valid_cycles;
    send_frame(8'h3C, 1'b0, 16, 20);
    step(64);
    checks++; if (ferr_cnt - f0 !== 1) begin failures++; $display("FAIL ferr_pulses got=%0d exp=1", ferr_cnt - f0); end
    checks++; if (valid_cycles - v0 !== 0) begin failures++; $display("FAIL ferr_valid got=%0d exp=0", valid_cycles - v0); end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 16, 0);
    wait_got(1);
    pop_pair(e, g);
    checks++; if (g !== e) begin failures++; $display("FAIL break_next_data got=%h exp=%h", g, e); end
  endtask

  task automatic test_overrun();
    int o0;
    logic [7:0] e, g;
    o0 = ovr_cnt;
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 16, 0);
    send_frame(8'h22, 1'b1, 16, 0);
    step(4);
    checks++; if (ovr_cnt - o0 !== 1) begin failures++; $display("FAIL ovr_pulses got=%0d exp=1", ovr_cnt - o0); end
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", rx_valid); end
    checks++; if (rx_data !== 8'h11) begin failures++; $display("FAIL ovr_data got=%h exp=11", rx_data); end
    step(100);
    checks++; if (rx_data !== 8'h11) begin failures++; $display("FAIL ovr_data_hold got=%h exp=11", rx_data); end
    rx_ready = 1'b1;
    wait_got(1);
    step(2);
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL ovr_count got=%0d exp=1", got_q.size()); end
    pop_pair(e, g);
    checks++; if (g !== e) begin failures++; $display("FAIL ovr_popped got=%h exp=%h", g, e); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL ovr_valid_clear got=%b exp=0", rx_valid); end
  endtask

  task automatic test_reset_midframe();
    int f0, o0, v0;
    logic [7:0] e, g;
    f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cycles;
    rxd = 1'b1;
    step(16);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rxd = 1'b1;
    step(10);
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(BIT_CLKS - 13);
    for (int i = 5; i < 8; i++) send_bit(1'b1);
    send_bit(1'b1);
    step(32);
    checks++; if (valid_cycles - v0 !== 0) begin failures++; $display("FAIL rst_mid_valid got=%0d exp=0", valid_cycles - v0); end
    checks++; if ((ferr_cnt - f0) + (ovr_cnt - o0) !== 0) begin failures++; $display("FAIL rst_mid_errors got=%0d exp=0", (ferr_cnt - f0) + (ovr_cnt - o0)); end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 16, 0);
    wait_got(1);
    pop_pair(e, g);
    checks++; if (g !== e) begin failures++; $display("FAIL rst_mid_next_data got=%h exp=%h", g, e); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e, g;
    rx_ready = 1'b1;
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h4E);
    send_frame(8'hC3, 1'b1, 16, 0);
    send_frame(8'h4E, 1'b1, 0, 0);
    wait_got(2);
    checks++; if (got_q.size() !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      pop_pair(e, g);
      checks++; if (g !== e) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", i, g, e); end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int p0;
    logic [7:0] e, g;
    p0 = perr_cnt;
    rx_ready = 1'b1;
    par_flip = 1'b1;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 16, 0);
    par_flip = 1'b0;
    wait_got(1);
    step(4);
    checks++; if (perr_cnt - p0 !== 1) begin failures++; $display("FAIL parity_pulses got=%0d exp=1", perr_cnt - p0); end
    pop_pair(e, g);
    checks++; if (g !== e) begin failures++; $display("FAIL parity_data got=%h exp=%h", g, e); end
  endtask
`endif

  initial begin
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
`endif
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err_break();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
